// File: rtl/canny_non_max_suppress.sv
// rtl/canny_non_max_suppress.sv - Canny non-maximum suppression over a 3x3 gradient window
// Two line buffers feed a 3x3 window; the centre survives only if it beats both gradient neighbours.
module canny_non_max_suppress #(
  parameter int DATA_DEPTH = 640,
  parameter int COL_W      = 10,
  parameter int ROW_W      = 10
) (
  input  logic        clk,
  input  logic        rst_s,
  input  logic        grandient_hs,
  input  logic        grandient_vs,
  input  logic        grandient_de,
  input  logic [15:0] gra_path,
  output logic        nms_hs,
  output logic        nms_vs,
  output logic        nms_de,
  output logic [1:0]  nms_edge,
  output logic [9:0]  nms_mag
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(DATA_DEPTH - 1);

  logic [1:0]       hs_dly, vs_dly, de_dly;
  logic             hs_fall, vs_rise;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;

  // Only the centre row needs flags and direction; rows r-2 and r carry magnitude only.
  logic [15:0] lb0 [DATA_DEPTH];
  logic [9:0]  lb1 [DATA_DEPTH];
  logic [15:0] rd0;
  logic [9:0]  rd1;

  logic [9:0]  p11, p12, p13, p21, p31, p32, p33;
  logic [15:0] p22, p23;
  logic        border_ok;

  logic        sel_ok, keep, keep2;
  logic [9:0]  mag_a, mag_b, mag2;
  logic [1:0]  cls, cls2;

  assign hs_fall = hs_dly[0] & ~grandient_hs;
  assign vs_rise = ~vs_dly[0] & grandient_vs;
  assign rd0     = lb0[col];
  assign rd1     = lb1[col];

  always_ff @(posedge clk) begin
    if (grandient_de && rst_s) begin
      lb0[col] <= gra_path;
      lb1[col] <= rd0[9:0];
    end
  end

  always_ff @(posedge clk or negedge rst_s) begin
    if (!rst_s) begin
      hs_dly <= '0;
      vs_dly <= '0;
      de_dly <= '0;
      col    <= '0;
      row    <= '0;
    end else begin
      hs_dly <= {hs_dly[0], grandient_hs};
      vs_dly <= {vs_dly[0], grandient_vs};
      de_dly <= {de_dly[0], grandient_de};
      if (hs_fall)
        col <= '0;
      else if (grandient_de && col != COL_LAST)
        col <= col + 1'b1;
      if (vs_rise)
        row <= '0;
      else if (hs_fall && row != '1)
        row <= row + 1'b1;
    end
  end

  // Window advances only on valid pixels; stale contents are masked by border_ok.
  always_ff @(posedge clk or negedge rst_s) begin
    if (!rst_s) begin
      p11 <= '0; p12 <= '0; p13 <= '0;
      p21 <= '0; p22 <= '0; p23 <= '0;
      p31 <= '0; p32 <= '0; p33 <= '0;
      border_ok <= 1'b0;
    end else if (grandient_de) begin
      p11 <= p12; p12 <= p13; p13 <= rd1;
      p21 <= p22[9:0]; p22 <= p23; p23 <= rd0;
      p31 <= p32; p32 <= p33; p33 <= gra_path[9:0];
      border_ok <= (row >= ROW_W'(2)) && (col >= COL_W'(2));
    end
  end

  always_comb begin
    sel_ok = 1'b1;
    mag_a  = '0;
    mag_b  = '0;
    case (p22[13:10])
      4'b0001: begin mag_a = p21; mag_b = p23[9:0]; end
      4'b0010: begin mag_a = p13; mag_b = p31;      end
      4'b0100: begin mag_a = p12; mag_b = p32;      end
      4'b1000: begin mag_a = p11; mag_b = p33;      end
      default: sel_ok = 1'b0;
    endcase
    // >= toward the earlier neighbour, > toward the later one: a flat ridge keeps one pixel.
    keep = sel_ok && border_ok && (p22[9:0] >= mag_a) && (p22[9:0] > mag_b);
    cls  = (p22[15:14] == 2'b11) ? 2'b10 : p22[15:14];
  end

  always_ff @(posedge clk or negedge rst_s) begin
    if (!rst_s) begin
      keep2    <= 1'b0;
      cls2     <= '0;
      mag2     <= '0;
      nms_hs   <= 1'b0;
      nms_vs   <= 1'b0;
      nms_de   <= 1'b0;
      nms_edge <= '0;
      nms_mag  <= '0;
    end else begin
      keep2    <= keep;
      cls2     <= cls;
      mag2     <= p22[9:0];
      nms_hs   <= hs_dly[1];
      nms_vs   <= vs_dly[1];
      nms_de   <= de_dly[1];
      nms_edge <= (de_dly[1] && keep2) ? cls2 : 2'b00;
      nms_mag  <= (de_dly[1] && keep2) ? mag2 : 10'd0;
    end
  end

endmodule
